// File: rtl/mfp_ahb_ram_ws.sv
// AHB-Lite slave RAM with programmable read wait states, ERROR responses for
// misaligned/oversize transfers and write-to-read forwarding on the same word.
module mfp_ahb_ram_ws #(
  parameter int ADDR_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HBURST,
  input  logic        HMASTLOCK,
  input  logic [3:0]  HPROT,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HWRITE,
  input  logic        HSEL,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_RD, ST_ERR1, ST_ERR2} state_t;

  state_t                  state, state_nxt;
  logic                    acc, illegal, adv, take, fwd_hit, wr_en;
  logic [3:0]              lane_mask, mask_r, fwd_mask;
  logic [ADDR_WIDTH-1:0]   haddr_w, addr_r, rd_addr;
  logic [31:0]             fwd_data, ram_q;
  logic [1:0]              wait_cnt;
  logic [31:0]             mem [0:(1<<ADDR_WIDTH)-1];
  logic                    unused_ok;

  assign unused_ok = ^{HBURST, HMASTLOCK, HPROT, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign acc     = HSEL & HREADY & HTRANS[1];
  assign haddr_w = HADDR[ADDR_WIDTH+1:2];

  always_comb begin
    lane_mask = '0;
    illegal   = 1'b0;
    case (HSIZE)
      3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
      3'd1:    begin
                 lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
                 illegal   = HADDR[0];
               end
      3'd2:    begin
                 lane_mask = '1;
                 illegal   = |HADDR[1:0];
               end
      default: illegal = 1'b1;
    endcase
  end

  // adv: this cycle is the final ready cycle, so a new address phase may be taken.
  always_comb begin
    adv       = !((state == ST_RD && wait_cnt != '0) || state == ST_ERR1);
    take      = adv & acc;
    state_nxt = ST_IDLE;
    if (!adv)
      state_nxt = (state == ST_ERR1) ? ST_ERR2 : ST_RD;
    else if (acc) begin
      if (illegal)     state_nxt = ST_ERR1;
      else if (HWRITE) state_nxt = ST_WR;
      else             state_nxt = ST_RD;
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      ST_RD:   HREADYOUT = (wait_cnt == '0);
      ST_ERR1: begin
                 HREADYOUT = 1'b0;
                 HRESP     = 1'b1;
               end
      ST_ERR2: HRESP = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    HRDATA = '0;
    if (state == ST_RD)
      for (int unsigned i = 0; i < 4; i++)
        HRDATA[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8] : ram_q[8*i +: 8];
  end

  // A read taken while ST_WR commits to the same word sees the RAM's old
  // contents; the written lanes are captured here and overlaid on HRDATA.
  assign fwd_hit = take & ~illegal & ~HWRITE & (state == ST_WR) & (haddr_w == addr_r);
  assign wr_en   = (state == ST_WR) & HRESETn;
  assign rd_addr = take ? haddr_w : addr_r;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_r   <= '0;
      mask_r   <= '0;
      fwd_mask <= '0;
      fwd_data <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        addr_r   <= haddr_w;
        mask_r   <= lane_mask;
        fwd_mask <= fwd_hit ? mask_r : '0;
        fwd_data <= HWDATA;
      end
      if (take & ~illegal & ~HWRITE)
        wait_cnt <= 2'(WAIT_STATES);
      else if (state == ST_RD && wait_cnt != '0)
        wait_cnt <= wait_cnt - 2'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_en)
      for (int unsigned i = 0; i < 4; i++)
        if (mask_r[i])
          mem[addr_r][8*i +: 8] <= HWDATA[8*i +: 8];
    ram_q <= mem[rd_addr];
  end

endmodule

// File: doc/mfp_ahb_ram_ws.md
Name: mfp_ahb_ram_ws

Overview:
AHB-Lite slave RAM, successor to the fixed-size byte-lane program RAM, on the MIPSfpga AHB bus behind the address decoder.
- Generalised in depth and read latency: programmable read wait states.
- Adds HREADYOUT/HRESP signalling, including an ERROR response for misaligned and oversize transfers.
- Adds write-to-read forwarding for back-to-back accesses to the same word.
- Lane selection uses HSIZE/HADDR only, never HBURST.

Parameters:
ADDR_WIDTH, 16, word-address bits; depth = 2^ADDR_WIDTH 32-bit words; byte address bits [ADDR_WIDTH+1:2] used.
WAIT_STATES, 0, read data-phase stall cycles, legal range 0..3; writes are always zero-wait.

Ports:
HCLK  in  1  bus clock; all state changes on its rising edge
HRESETn  in  1  synchronous active-low reset, sampled on rising HCLK
HADDR  in  32  address-phase byte address
HBURST  in  3  ignored
HMASTLOCK  in  1  ignored
HPROT  in  4  ignored
HSIZE  in  3  transfer size (0 byte, 1 half, 2 word)
HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
HWDATA  in  32  data-phase write data
HWRITE  in  1  1 = write
HSEL  in  1  slave select from decoder
HREADY  in  1  bus-wide ready; the address phase is valid only when this is 1
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  1  0 OKAY, 1 ERROR

Behaviour:
- Accept condition: `acc = HSEL & HREADY & HTRANS[1]`. IDLE/BUSY transfers and unselected cycles get zero-wait OKAY with no memory access.
- Lane mask, byte: `4'b0001 << HADDR[1:0]`.
- Lane mask, half-word: HADDR[1] ? 1100 : 0011.
- Lane mask, word: 1111.
- Illegal transfer: half-word with HADDR[0]=1, word with HADDR[1:0]≠0, or HSIZE>2.
  - Response is ERROR, with no memory write and no read.
- FSM states, registered: ST_IDLE, ST_WR, ST_RD, ST_ERR1, ST_ERR2.
- Every state exits to the next-transfer state when `acc`, otherwise to ST_IDLE. The exceptions are:
  - ST_RD with a nonzero wait count.
  - ST_ERR1.
- Next-transfer state on `acc`: illegal → ST_ERR1; write → ST_WR; read → ST_RD.
- On entry to ST_RD, the wait counter loads WAIT_STATES.
- ST_WR (data phase):
  - HREADYOUT=1, HRESP=0.
  - On the exiting edge, the lanes of HWDATA selected by the registered mask are written to the registered word address.
- ST_RD:
  - HREADYOUT=0 while the wait counter ≠ 0; the counter decrements each cycle.
  - When the counter = 0: HREADYOUT=1, HRDATA valid, OKAY.
  - With WAIT_STATES=0 the read has a single data-phase cycle.
  - The RAM read address is HADDR on the accept edge, then held at the registered address, so HRDATA is stable for the whole data phase.
- ST_ERR1: HREADYOUT=0, HRESP=1; always goes to ST_ERR2.
- ST_ERR2: HREADYOUT=1, HRESP=1; follows the normal exit rule.
- The address phase of the next transfer coincides with the final ready cycle (ST_WR, the last ST_RD cycle, or ST_ERR2). Transfers presented while HREADYOUT=0 are not accepted (HREADY is low).
- HRDATA:
  - HRDATA = 0 in every state other than ST_RD.
  - In ST_RD, HRDATA = RAM output with forwarding applied.
- Forwarding (read-after-write):
  - Applies when a read is accepted in the same cycle that ST_WR commits to the same word address.
  - The written lanes of that HWDATA are captured and substituted into HRDATA for the read's data phase.
  - Unwritten lanes come from the RAM.
  - The RAM read-during-write result is never exposed.
- Reset (HRESETn=0 at an edge):
  - state → ST_IDLE, wait counter → 0.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - A pending ST_WR commit at that same edge is discarded.
  - RAM contents are not cleared.
- Address wrap: bits above ADDR_WIDTH+1 are ignored, so the memory aliases.

Test Plan:
- Reset, WAIT_STATES=0 → HREADYOUT=1, HRESP=0, HRDATA=0. Then word write 0xDEADBEEF @0x10 followed by a word read @0x10 → HRDATA=0xDEADBEEF in the data phase, no stall.
- Byte writes 0x11@0x20, 0x22@0x21, half-word 0x4433@0x22, then word read @0x20 → 0x44332211. An HBURST=INCR4 on the byte write must not change the mask.
- Back-to-back: word 0xAAAAAAAA@0x30, then byte write 0x55@0x31 immediately followed by a read @0x30 → 0xAAAA55AA via forwarding.
- WAIT_STATES=2, read @0x10 → HREADYOUT low for exactly 2 cycles, then high with 0xDEADBEEF. A NONSEQ held during the stall is accepted only after HREADY rises.
- Misaligned word write @0x12 with HWDATA=0x12345678 → HREADYOUT 0 then 1, HRESP 1 for both cycles; a read @0x10 afterwards returns 0xDEADBEEF unchanged. Also check that HSIZE=3 gives the same ERROR response.
- HRESETn low at the ST_WR commit edge of a write 0xCAFEF00D@0x40 → location 0x40 keeps its old value; outputs return to their reset values.
